// File: rtl/ble_pkt_pkg.sv
// ble_pkt_pkg: shared constants, FSM state type and whitening seed helper
// for the BLE PDU checker.
package ble_pkt_pkg;

    localparam logic [23:0] CRC_POLY     = 24'h00065B;
    localparam logic [23:0] CRC_INIT_ADV = 24'h555555;
    localparam int          AA_LEN       = 32;
    localparam int          HDR_LEN      = 16;
    localparam int          CRC_LEN      = 24;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CRC,
        DONE
    } pdu_state_t;

    // Channel index bit-reversed into w[6:1]; w[0] is always 1.
    function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    endfunction

endpackage

// File: rtl/ble_pdu_checker_if.sv
// ble_pdu_checker_if: byte stream from the PDU checker to the packet buffer.
//   o_byte  - header/payload byte, LSB-first assembled
//   o_valid - o_byte valid
//   i_ready - consumer accepts when o_valid && i_ready
//   o_last  - final PDU byte of a packet
// master: checker side, slave: consumer side.
interface ble_pdu_checker_if;
    logic [7:0] o_byte;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;

    modport master (output o_byte, output o_valid, output o_last, input i_ready);
    modport slave  (input o_byte, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/ble_dewhiten_crc.sv
// ble_dewhiten_crc: bit engine. Holds the whitening LFSR w and the CRC-24
// register c. One received bit is dewhitened per step; the CRC absorbs the
// dewhitened bit.
//   load    - seed w from channel, preset c from crc_init
//   step    - advance w and c by one bit
//   stall   - suppresses step while the byte output is blocked
//   bit_in  - raw on-air bit
//   d       - dewhitened bit (combinational)
//   c       - current CRC register
module ble_dewhiten_crc
    import ble_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic        stall,
    input  logic        bit_in,
    input  logic [5:0]  channel,
    input  logic [23:0] crc_init,
    output logic        d,
    output logic [23:0] c
);

    logic [6:0] w;
    logic       fb;

    assign d  = bit_in ^ w[6];
    assign fb = c[23] ^ d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w <= '0;
            c <= '0;
        end else if (load) begin
            w <= whiten_seed(channel);
            c <= crc_init;
        end else if (step && !stall) begin
            w <= {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
            c <= {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
        end
    end

endmodule

// File: rtl/ble_pdu_checker.sv
// ble_pdu_checker: takes packets from ble_cdr, skips the access address,
// dewhitens PDU+CRC, checks CRC-24 and streams header/payload bytes out.
//   clk, resetn      - clock, async active-low reset
//   en               - global enable; low freezes every register
//   packet_in/len    - sniffer packet (bit 0 first on air) and valid bit count
//   packet_detected  - level; a rising edge starts a packet
//   channel/crc_init - whitening channel and CRC preset
//   pdu              - byte stream (o_byte/o_valid/i_ready/o_last)
//   busy/done        - packet in progress / one-cycle end pulse
//   crc_ok/len_err   - per-packet result, held until next start
//   overrun          - sticky: a packet edge arrived while busy
// Optional (macro PDU_CHECK_STATS_EN): stats_clr input and saturating
// good_cnt/bad_cnt outputs.
module ble_pdu_checker
    import ble_pkt_pkg::*;
#(
    parameter int MAX_PACKET_LEN = 376,
    parameter int PREAMBLE_LEN   = 8,
    localparam int PKT_W         = MAX_PACKET_LEN - PREAMBLE_LEN,
    localparam int MAX_PDU_BYTES = (PKT_W - AA_LEN - CRC_LEN) / 8,
    localparam int LEN_W         = $clog2(MAX_PACKET_LEN)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
`ifdef PDU_CHECK_STATS_EN
    input  logic                   stats_clr,
    output logic [15:0]            good_cnt,
    output logic [15:0]            bad_cnt,
`endif
    input  logic [PKT_W-1:0]       packet_in,
    input  logic [LEN_W-1:0]       packet_len,
    input  logic                   packet_detected,
    input  logic [5:0]             channel,
    input  logic [23:0]            crc_init,
    ble_pdu_checker_if.master      pdu,
    output logic                   busy,
    output logic                   done,
    output logic                   crc_ok,
    output logic                   len_err,
    output logic                   overrun
);

    // state   | meaning
    // IDLE    | waiting for a packet_detected rising edge
    // HDR     | 16 header bits
    // PAYLOAD | 8*L payload bits
    // CRC     | 24 CRC bits; with no bits left, waits for the last byte to drain
    // DONE    | one cycle, done pulse

    localparam int          IDX_W      = $clog2(PKT_W);
    localparam int          CNT_W      = $clog2(8 * MAX_PDU_BYTES);
    localparam logic [7:0]  MAX_L      = 8'(MAX_PDU_BYTES - 2);
    localparam logic [11:0] FIXED_BITS = 12'(AA_LEN + HDR_LEN + CRC_LEN);

    pdu_state_t        state, state_d;
    logic              pd_s, pd_q;
    logic [PKT_W-1:0]  pkt_q;
    logic [LEN_W-1:0]  len_q;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [6:0]        asm_q;

    logic              d;
    logic [23:0]       c;
    logic              rise, start, active, bits_left, last_bit;
    logic              byte_end, stall, step, adv, drain_ok;
    logic [7:0]        new_byte;
    logic [11:0]       need_bits;
    logic              len_bad, crc_zero;

    assign rise      = pd_s && !pd_q;
    assign start     = en && (state == IDLE) && rise;
    assign active    = (state == HDR) || (state == PAYLOAD) || (state == CRC);
    assign bits_left = (bit_cnt != '0);
    assign last_bit  = (bit_cnt == CNT_W'(1));
    // Byte boundaries fall where the remaining-bit count is 1 mod 8.
    assign byte_end  = ((state == HDR) || (state == PAYLOAD)) && (bit_cnt[2:0] == 3'd1);
    assign stall     = byte_end && pdu.o_valid && !pdu.i_ready;
    assign step      = en && active && bits_left;
    assign adv       = step && !stall;
    assign drain_ok  = !pdu.o_valid || pdu.i_ready;
    assign new_byte  = {d, asm_q};

    // new_byte is the length field when the last header bit is processed.
    assign need_bits = FIXED_BITS + {1'b0, new_byte, 3'b000};
    assign len_bad   = (new_byte > MAX_L) || (12'(len_q) < need_bits);

    // The CRC update after the current bit is zero only when c[22:0] is zero
    // and no feedback occurs (the polynomial's bit 0 is set).
    assign crc_zero  = (c[22:0] == 23'd0) && (c[23] == d);

    assign busy = active;
    assign done = (state == DONE);

    ble_dewhiten_crc u_engine (
        .clk      (clk),
        .resetn   (resetn),
        .load     (start),
        .step     (step),
        .stall    (stall),
        .bit_in   (pkt_q[idx]),
        .channel  (channel),
        .crc_init (crc_init),
        .d        (d),
        .c        (c)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                if (adv && last_bit) begin
                    if (len_bad || new_byte == 8'd0) state_d = CRC;
                    else                             state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (adv && last_bit) state_d = CRC;
            end
            CRC: begin
                if (adv && last_bit && drain_ok)         state_d = DONE;
                else if (en && !bits_left && drain_ok)   state_d = DONE;
            end
            DONE: begin
                if (en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pd_s        <= 1'b0;
            pd_q        <= 1'b0;
            pkt_q       <= '0;
            len_q       <= '0;
            idx         <= '0;
            bit_cnt     <= '0;
            asm_q       <= '0;
            crc_ok      <= 1'b0;
            len_err     <= 1'b0;
            overrun     <= 1'b0;
            pdu.o_byte  <= 8'd0;
            pdu.o_valid <= 1'b0;
            pdu.o_last  <= 1'b0;
        end else if (en) begin
            pd_s  <= packet_detected;
            pd_q  <= pd_s;
            state <= state_d;

            if (start) begin
                pkt_q   <= packet_in;
                len_q   <= packet_len;
                idx     <= IDX_W'(AA_LEN);
                bit_cnt <= CNT_W'(HDR_LEN);
                crc_ok  <= 1'b0;
                len_err <= 1'b0;
                overrun <= 1'b0;
            end else if (rise && state != IDLE) begin
                overrun <= 1'b1;
            end

            if (adv) begin
                idx     <= idx + IDX_W'(1);
                asm_q   <= {d, asm_q[6:1]};
                bit_cnt <= bit_cnt - CNT_W'(1);
                if (last_bit) begin
                    case (state)
                        HDR: begin
                            if (len_bad) begin
                                len_err <= 1'b1;
                                bit_cnt <= '0;
                            end else if (new_byte == 8'd0) begin
                                bit_cnt <= CNT_W'(CRC_LEN);
                            end else begin
                                bit_cnt <= CNT_W'({new_byte, 3'b000});
                            end
                        end
                        PAYLOAD: bit_cnt <= CNT_W'(CRC_LEN);
                        CRC:     crc_ok  <= crc_zero;
                        default: ;
                    endcase
                end
            end

            if (adv && byte_end) begin
                pdu.o_byte  <= new_byte;
                pdu.o_valid <= 1'b1;
                pdu.o_last  <= last_bit && ((state == PAYLOAD) ||
                               (!len_bad && new_byte == 8'd0));
            end else if (pdu.o_valid && pdu.i_ready) begin
                pdu.o_valid <= 1'b0;
                pdu.o_last  <= 1'b0;
            end
        end
    end

`ifdef PDU_CHECK_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else if (en) begin
            if (stats_clr) begin
                good_cnt <= 16'd0;
                bad_cnt  <= 16'd0;
            end else if (state == DONE) begin
                if (crc_ok && !len_err) begin
                    if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                end else begin
                    if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ble_pdu_checker.sv
// tb_ble_pdu_checker: directed vectors for ble_pdu_checker. Packets are built
// by an encoder model (CRC-24 over the PDU, CRC appended MSB-first, then
// whitened), so the expected bytes are the original PDU bytes.
module tb_ble_pdu_checker;

    localparam int PKT_W = 368;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             en = 1'b1;
    logic [PKT_W-1:0] packet_in = '0;
    logic [8:0]       packet_len = '0;
    logic             packet_detected = 1'b0;
    logic [5:0]       channel = '0;
    logic [23:0]      crc_init = '0;
    logic             busy, done, crc_ok, len_err, overrun;
`ifdef PDU_CHECK_STATS_EN
    logic             stats_clr = 1'b0;
    logic [15:0]      good_cnt, bad_cnt;
`endif

    ble_pdu_checker_if bus ();

    ble_pdu_checker dut (
        .clk             (clk),
        .resetn          (resetn),
        .en              (en),
`ifdef PDU_CHECK_STATS_EN
        .stats_clr       (stats_clr),
        .good_cnt        (good_cnt),
        .bad_cnt         (bad_cnt),
`endif
        .packet_in       (packet_in),
        .packet_len      (packet_len),
        .packet_detected (packet_detected),
        .channel         (channel),
        .crc_init        (crc_init),
        .pdu             (bus),
        .busy            (busy),
        .done            (done),
        .crc_ok          (crc_ok),
        .len_err         (len_err),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]       pdu_b [0:39];
    logic [PKT_W-1:0] pkt_v;

    typedef struct {
        logic [5:0]  ch;
        logic [23:0] init;
        int          l;
        int          plen;
        int          flip;
        int          rdy_p;
        int          en_gap;
        bit          exp_crc;
        bit          exp_lerr;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Encoder: AA, PDU bytes LSB-first, CRC MSB-first, whitening from bit 32.
    task automatic build_pkt(input logic [5:0] ch, input logic [23:0] init, input int nb);
        logic [23:0] c;
        logic [23:0] crcv;
        logic [6:0]  w;
        logic        b;
        logic        fb;
        pkt_v = '0;
        pkt_v[31:0] = 32'h8E89BED6;
        c = init;
        w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
        for (int k = 0; k < nb * 8; k++) begin
            b  = pdu_b[k / 8][k % 8];
            fb = c[23] ^ b;
            c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
            pkt_v[32 + k] = b ^ w[6];
            w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
        end
        crcv = c;
        for (int k = 0; k < 24; k++) begin
            b = crcv[23 - k];
            pkt_v[32 + nb * 8 + k] = b ^ w[6];
            w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
        end
    endtask

    task automatic fill_pdu(input logic [5:0] ch, input int l);
        pdu_b[0] = 8'h40 ^ {2'b00, ch};
        pdu_b[1] = 8'(l);
        for (int k = 2; k < 40; k++) pdu_b[k] = 8'(k * 29 + 60) ^ {2'b00, ch};
    endtask

    task automatic start_pkt(input logic [5:0] ch, input logic [23:0] init,
                             input int l, input int plen, input int flip);
        int nb;
        logic [7:0] t;
        fill_pdu(ch, l);
        nb = (2 + l > 39) ? 2 : 2 + l;
        build_pkt(ch, init, nb);
        if (flip >= 0) begin
            pkt_v[32 + flip] = ~pkt_v[32 + flip];
            t = pdu_b[flip / 8];
            t[flip % 8] = ~t[flip % 8];
            pdu_b[flip / 8] = t;
        end
        @(posedge clk); #1;
        packet_in       = pkt_v;
        packet_len      = 9'(plen);
        channel         = ch;
        crc_init        = init;
        packet_detected = 1'b1;
    endtask

    // Iteration j samples just after edge N+j-1, N being the edge that first
    // samples packet_detected high; done for an unstalled packet is high in
    // the cycle ending at edge N+2+40+8L.
    task automatic run_packet(input string name, input logic [5:0] ch, input logic [23:0] init,
                              input int l, input int plen, input int flip, input int rdy_p,
                              input int en_gap, input bit glitch, input bit exp_crc,
                              input bit exp_lerr, input bit exp_ovr);
        logic [7:0] got_b [0:47];
        int got, nlast, last_pos, lat, n_exp;
        bit seen_done;
        got = 0; nlast = 0; last_pos = -1; lat = 0; seen_done = 0;
        n_exp = exp_lerr ? 2 : 2 + l;
        start_pkt(ch, init, l, plen, flip);
        for (int j = 1; j <= 3000 && !seen_done; j++) begin
            @(posedge clk); #1;
            if (en_gap > 0) en = !(j >= 30 && j < 30 + en_gap);
            if (glitch) begin
                if (j == 5)  packet_in = ~pkt_v;
                if (j == 20) packet_detected = 1'b0;
                if (j == 22) packet_detected = 1'b1;
            end
            bus.i_ready = ((j % rdy_p) == 0);
            if (bus.o_valid && bus.i_ready && en) begin
                if (got < 48) got_b[got] = bus.o_byte;
                if (bus.o_last) begin
                    nlast++;
                    last_pos = got;
                end
                got++;
            end
            if (done) begin
                seen_done = 1;
                lat = j;
            end
        end
        check({name, " done_seen"}, 32'(seen_done), 32'd1);
        check({name, " crc_ok"}, 32'(crc_ok), 32'(exp_crc));
        check({name, " len_err"}, 32'(len_err), 32'(exp_lerr));
        check({name, " overrun"}, 32'(overrun), 32'(exp_ovr));
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
        check({name, " nbytes"}, 32'(got), 32'(n_exp));
        for (int k = 0; k < n_exp && k < got; k++)
            check($sformatf("%s byte%0d", name, k), 32'(got_b[k]), 32'(pdu_b[k]));
        check({name, " nlast"}, 32'(nlast), exp_lerr ? 32'd0 : 32'd1);
        if (!exp_lerr) check({name, " last_pos"}, 32'(last_pos), 32'(n_exp - 1));
        if (rdy_p == 1 && !exp_lerr)
            check({name, " latency"}, 32'(lat), 32'(2 + 40 + 8 * l + en_gap));
        en = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check({name, " done_pulse"}, 32'(done), 32'd0);
        packet_detected = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        vecs[0]  = '{6'd37, 24'h555555, 6,  120, -1, 1,  0,  1'b1, 1'b0};
        vecs[1]  = '{6'd37, 24'h555555, 6,  120, 42, 1,  0,  1'b0, 1'b0};
        vecs[2]  = '{6'd37, 24'h555555, 40, 375, -1, 1,  0,  1'b0, 1'b1};
        vecs[3]  = '{6'd37, 24'h555555, 6,  100, -1, 1,  0,  1'b0, 1'b1};
        vecs[4]  = '{6'd12, 24'h123456, 0,  72,  -1, 1,  0,  1'b1, 1'b0};
        vecs[5]  = '{6'd37, 24'h555555, 6,  120, -1, 3,  0,  1'b1, 1'b0};
        vecs[6]  = '{6'd5,  24'h555555, 1,  80,  -1, 40, 0,  1'b1, 1'b0};
        vecs[7]  = '{6'd39, 24'h555555, 37, 368, -1, 1,  0,  1'b1, 1'b0};
        vecs[8]  = '{6'd37, 24'h555555, 6,  120, -1, 1,  10, 1'b1, 1'b0};
        vecs[9]  = '{6'd20, 24'h555555, 38, 375, -1, 1,  0,  1'b0, 1'b1};
        vecs[10] = '{6'd37, 24'h555555, 6,  119, -1, 1,  0,  1'b0, 1'b1};

        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst o_byte",  32'(bus.o_byte),  32'd0);
        check("rst o_valid", 32'(bus.o_valid), 32'd0);
        check("rst o_last",  32'(bus.o_last),  32'd0);
        check("rst busy",    32'(busy),        32'd0);
        check("rst done",    32'(done),        32'd0);
        check("rst crc_ok",  32'(crc_ok),      32'd0);
        check("rst len_err", 32'(len_err),     32'd0);
        check("rst overrun", 32'(overrun),     32'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 11; v++)
            run_packet($sformatf("v%0d", v), vecs[v].ch, vecs[v].init, vecs[v].l, vecs[v].plen,
                       vecs[v].flip, vecs[v].rdy_p, vecs[v].en_gap, 1'b0,
                       vecs[v].exp_crc, vecs[v].exp_lerr, 1'b0);

        // Second rising edge mid-packet, packet_in scrambled after the snapshot.
        run_packet("ovr", 6'd37, 24'h555555, 6, 120, -1, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        // The next accepted start clears overrun.
        run_packet("post_ovr", 6'd8, 24'h555555, 3, 96, -1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset around bit 50 of a packet.
        start_pkt(6'd37, 24'h555555, 6, 120, -1);
        repeat (52) @(posedge clk);
        #1;
        check("rst_mid busy_before", 32'(busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid busy",    32'(busy),        32'd0);
        check("rst_mid o_valid", 32'(bus.o_valid), 32'd0);
        check("rst_mid o_byte",  32'(bus.o_byte),  32'd0);
        check("rst_mid o_last",  32'(bus.o_last),  32'd0);
        check("rst_mid done",    32'(done),        32'd0);
        packet_detected = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        run_packet("after_rst", 6'd37, 24'h555555, 6, 120, -1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef PDU_CHECK_STATS_EN
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        check("stats cleared", 32'(good_cnt), 32'd0);
        run_packet("s_g0", 6'd37, 24'h555555, 6, 120, -1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_packet("s_g1", 6'd12, 24'h123456, 0, 72,  -1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_packet("s_b0", 6'd37, 24'h555555, 6, 120, 42, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_packet("s_g2", 6'd5,  24'h555555, 1, 80,  -1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stats good_cnt", 32'(good_cnt), 32'd3);
        check("stats bad_cnt",  32'(bad_cnt),  32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
